bingo_game_node: RTL and testbench

Parametrised two-board bingo game controller; successor to the fixed 5x5 per-role game tops.
- One module serves either role, selected by IS_MASTER.
- Contains the number-entry (selection) logic, number-to-cell lookup, circle marking and line counting, so no separate select/guess/win submodules are needed.
- Sits between the keypad/number-entry front end and the interboard link transceiver, using the team's STATE_TURN / SEL_NUM / STATE_WIN message codes.

---
 rtl/bingo_game_node.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_bingo_game_node.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bingo_game_node.sv
// Two-board bingo game node: number entry, number-to-cell lookup, circle marking,
// line counting and the turn handshake with the peer board over the interboard link.
module bingo_game_node #(
  parameter int N            = 5,
  parameter int NUM_W        = 5,
  parameter int LINES_TO_WIN = 1,
  parameter int TURN_TIMEOUT = 0,
  parameter int IS_MASTER    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       interboard_rst,
  input  logic [NUM_W-1:0]           cur_number,
  input  logic                       enter_pulse,
  input  logic                       inter_ready,
  input  logic                       rx_en,
  input  logic [2:0]                 rx_msg_type,
  input  logic [NUM_W-1:0]           rx_number,
  output logic                       transmit,
  output logic                       tx_en,
  output logic [2:0]                 tx_msg_type,
  output logic [NUM_W-1:0]           tx_number,
  output logic [NUM_W*N*N-1:0]       map,
  output logic [N*N-1:0]             circle,
  output logic [$clog2(2*N+3)-1:0]   line_count,
  output logic                       won,
  output logic                       timeout_flag
);
  localparam logic [2:0] STATE_TURN = 3'd1;
  localparam logic [2:0] SEL_NUM    = 3'd2;
  localparam logic [2:0] STATE_WIN  = 3'd3;

  localparam int CELLS = N * N;
  localparam int NUMS  = 2 ** NUM_W;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int LC_W  = $clog2(2 * N + 3);
  localparam int TMR_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEND_START, ST_SEL, ST_WAIT_PEER_SEL, ST_SEND_READY,
    ST_WAIT_PEER_GUESS, ST_MARK_PEER, ST_CHECK_PEER, ST_MY_GUESS,
    ST_CHECK_OWN, ST_SEND_SEL, ST_SEND_WIN, ST_FIN
  } state_t;

  state_t                       state_q;
  logic [CELLS-1:0][NUM_W-1:0]  map_q;
  logic [IDX_W-1:0]             pos_q [NUMS];
  logic [NUMS-1:0]              used_q;
  logic [NUMS-1:0]              guessed_q;
  logic [CELLS-1:0]             circle_q;
  logic [IDX_W-1:0]             cell_idx_q;
  logic                         peer_ready_q;
  logic [TMR_W-1:0]             timer_q;
  logic [NUM_W-1:0]             peer_num_q;
  logic                         transmit_q;
  logic                         tx_en_q;
  logic [2:0]                   tx_type_q;
  logic [NUM_W-1:0]             tx_num_q;
  logic [LC_W-1:0]              line_count_q;
  logic                         won_q;
  logic                         timeout_q;

  logic [LC_W-1:0]  lines_d;
  logic [N-1:0]     row_full;
  logic [N-1:0]     col_full;
  logic [N-1:0]     diag_bits;
  logic [N-1:0]     anti_bits;
  logic [NUM_W-1:0] auto_num;
  logic             auto_ok;
  logic             sel_wr;
  logic             own_valid;
  logic             auto_fire;
  logic [NUM_W-1:0] guess_num;
  logic             rx_turn;
  logic             rx_sel;
  logic             rx_win;
  logic             win_now;
  logic             send_done;

  function automatic logic is_valid(input logic [NUM_W-1:0] n);
    return (n != '0) && (32'(n) <= CELLS);
  endfunction

  // Full-line detection over the circle bitmap
  for (genvar gi = 0; gi < N; gi++) begin : g_lines
    logic [N-1:0] row_bits;
    logic [N-1:0] col_bits;
    for (genvar gj = 0; gj < N; gj++) begin : g_cell
      assign row_bits[gj] = circle_q[gi*N + gj];
      assign col_bits[gj] = circle_q[gj*N + gi];
    end
    assign row_full[gi]  = &row_bits;
    assign col_full[gi]  = &col_bits;
    assign diag_bits[gi] = circle_q[gi*N + gi];
    assign anti_bits[gi] = circle_q[gi*N + (N-1-gi)];
  end

  always_comb begin
    lines_d = '0;
    for (int i = 0; i < N; i++) begin
      lines_d = lines_d + LC_W'(row_full[i]) + LC_W'(col_full[i]);
    end
    lines_d = lines_d + LC_W'(&diag_bits) + LC_W'(&anti_bits);
  end

  // Smallest unguessed legal number, used by the turn timeout
  always_comb begin
    auto_num = '0;
    auto_ok  = 1'b0;
    for (int i = CELLS; i >= 1; i--) begin
      if (!guessed_q[i]) begin
        auto_num = NUM_W'(i);
        auto_ok  = 1'b1;
      end
    end
  end

  assign rx_turn   = rx_en && (rx_msg_type == STATE_TURN);
  assign rx_sel    = rx_en && (rx_msg_type == SEL_NUM) && is_valid(rx_number);
  assign rx_win    = rx_en && (rx_msg_type == STATE_WIN);
  assign sel_wr    = (state_q == ST_SEL) && enter_pulse && is_valid(cur_number) && !used_q[cur_number];
  assign own_valid = (state_q == ST_MY_GUESS) && enter_pulse && is_valid(cur_number)
                     && !guessed_q[cur_number];
  assign auto_fire = (TURN_TIMEOUT > 0) && (state_q == ST_MY_GUESS) && !own_valid && auto_ok
                     && (timer_q == TMR_W'(TURN_TIMEOUT - 1));
  assign guess_num = own_valid ? cur_number : auto_num;
  assign win_now   = 32'(lines_d) >= LINES_TO_WIN;
  // A send state may only exit after its launch cycle
  assign send_done = inter_ready && !tx_en_q;

  always_ff @(posedge clk) begin
    if (sel_wr) pos_q[cur_number] <= cell_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q      <= ST_IDLE;
      map_q        <= '0;
      used_q       <= '0;
      guessed_q    <= '0;
      circle_q     <= '0;
      cell_idx_q   <= '0;
      peer_ready_q <= 1'b0;
      timer_q      <= '0;
      peer_num_q   <= '0;
      transmit_q   <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_type_q    <= '0;
      tx_num_q     <= '0;
      line_count_q <= '0;
      won_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      tx_en_q      <= 1'b0;
      timeout_q    <= 1'b0;
      line_count_q <= lines_d;
      case (state_q)
        ST_IDLE: begin
          if (IS_MASTER != 0) begin
            if (enter_pulse) begin
              state_q    <= ST_SEND_START;
              transmit_q <= 1'b1;
              tx_en_q    <= 1'b1;
              tx_type_q  <= STATE_TURN;
              tx_num_q   <= '0;
            end
          end else if (rx_turn) begin
            state_q <= ST_SEL;
          end
        end
        ST_SEND_START: begin
          if (send_done) begin
            state_q    <= ST_SEL;
            transmit_q <= 1'b0;
          end
        end
        ST_SEL: begin
          if ((IS_MASTER != 0) && rx_turn) peer_ready_q <= 1'b1;
          if (sel_wr) begin
            map_q[cell_idx_q]  <= cur_number;
            used_q[cur_number] <= 1'b1;
            cell_idx_q         <= cell_idx_q + 1'b1;
            if (cell_idx_q == IDX_W'(CELLS - 1)) begin
              if (IS_MASTER != 0) begin
                state_q <= ST_WAIT_PEER_SEL;
              end else begin
                state_q    <= ST_SEND_READY;
                transmit_q <= 1'b1;
                tx_en_q    <= 1'b1;
                tx_type_q  <= STATE_TURN;
                tx_num_q   <= '0;
              end
            end
          end
        end
        ST_WAIT_PEER_SEL: begin
          if (peer_ready_q || rx_turn) begin
            state_q      <= ST_MY_GUESS;
            peer_ready_q <= 1'b0;
            timer_q      <= '0;
          end
        end
        ST_SEND_READY: begin
          if (send_done) begin
            state_q    <= ST_WAIT_PEER_GUESS;
            transmit_q <= 1'b0;
          end
        end
        ST_WAIT_PEER_GUESS: begin
          if (rx_sel) begin
            peer_num_q <= rx_number;
            state_q    <= ST_MARK_PEER;
          end else if (rx_win) begin
            won_q   <= 1'b0;
            state_q <= ST_FIN;
          end
        end
        ST_MARK_PEER: begin
          circle_q[pos_q[peer_num_q]] <= 1'b1;
          guessed_q[peer_num_q]       <= 1'b1;
          state_q                     <= ST_CHECK_PEER;
        end
        ST_CHECK_PEER: begin
          if (win_now) begin
            state_q    <= ST_SEND_WIN;
            transmit_q <= 1'b1;
            tx_en_q    <= 1'b1;
            tx_type_q  <= STATE_WIN;
          end else begin
            state_q <= ST_MY_GUESS;
            timer_q <= '0;
          end
        end
        ST_MY_GUESS: begin
          if (own_valid || auto_fire) begin
            circle_q[pos_q[guess_num]] <= 1'b1;
            guessed_q[guess_num]       <= 1'b1;
            tx_num_q                   <= guess_num;
            timeout_q                  <= auto_fire;
            state_q                    <= ST_CHECK_OWN;
          end else if (TURN_TIMEOUT > 0) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_CHECK_OWN: begin
          transmit_q <= 1'b1;
          tx_en_q    <= 1'b1;
          if (win_now) begin
            state_q   <= ST_SEND_WIN;
            tx_type_q <= STATE_WIN;
          end else begin
            state_q   <= ST_SEND_SEL;
            tx_type_q <= SEL_NUM;
          end
        end
        ST_SEND_SEL: begin
          if (send_done) begin
            state_q    <= ST_WAIT_PEER_GUESS;
            transmit_q <= 1'b0;
          end
        end
        ST_SEND_WIN: begin
          if (send_done) begin
            state_q    <= ST_FIN;
            transmit_q <= 1'b0;
            won_q      <= 1'b1;
          end
        end
        ST_FIN: begin
          if (rx_turn) begin
            state_q      <= ST_IDLE;
            map_q        <= '0;
            used_q       <= '0;
            guessed_q    <= '0;
            circle_q     <= '0;
            cell_idx_q   <= '0;
            peer_ready_q <= 1'b0;
            won_q        <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign transmit     = transmit_q;
  assign tx_en        = tx_en_q;
  assign tx_msg_type  = tx_type_q;
  assign tx_number    = tx_num_q;
  assign map          = map_q;
  assign circle       = circle_q;
  assign line_count   = line_count_q;
  assign won          = won_q;
  assign timeout_flag = timeout_q;
endmodule

// File: tb/tb_bingo_game_node.sv
// Directed bench for bingo_game_node: one slave and three master variants
// (N=5 basic, N=3 with two lines to win, N=5 with an 8-cycle turn timeout).
module tb_bingo_game_node;
  localparam int ND = 4;
  localparam logic [2:0] STATE_TURN = 3'd1;
  localparam logic [2:0] SEL_NUM    = 3'd2;
  localparam logic [2:0] STATE_WIN  = 3'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ib_rst      [ND];
  logic [4:0]   cur_number  [ND];
  logic         enter_pulse [ND];
  logic         inter_ready [ND];
  logic         rx_en       [ND];
  logic [2:0]   rx_type     [ND];
  logic [4:0]   rx_num      [ND];
  logic         transmit    [ND];
  logic         tx_en       [ND];
  logic [2:0]   tx_type     [ND];
  logic [4:0]   tx_num      [ND];
  logic [3:0]   lc          [ND];
  logic         won         [ND];
  logic         tflag       [ND];
  logic [124:0] map_a       [ND];
  logic [24:0]  circ_a      [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt [ND] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) if (tx_en[d] === 1'b1) tx_cnt[d] <= tx_cnt[d] + 1;
  end

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int PN = (gi == 2) ? 3 : 5;
    localparam int PL = (gi == 2) ? 2 : 1;
    localparam int PT = (gi == 3) ? 8 : 0;
    localparam int PM = (gi == 0) ? 0 : 1;
    logic [5*PN*PN-1:0] map_w;
    logic [PN*PN-1:0]   circ_w;
    bingo_game_node #(.N(PN), .NUM_W(5), .LINES_TO_WIN(PL), .TURN_TIMEOUT(PT), .IS_MASTER(PM)) u_dut (
      .clk(clk), .rst(rst), .interboard_rst(ib_rst[gi]),
      .cur_number(cur_number[gi]), .enter_pulse(enter_pulse[gi]),
      .inter_ready(inter_ready[gi]), .rx_en(rx_en[gi]),
      .rx_msg_type(rx_type[gi]), .rx_number(rx_num[gi]),
      .transmit(transmit[gi]), .tx_en(tx_en[gi]), .tx_msg_type(tx_type[gi]),
      .tx_number(tx_num[gi]), .map(map_w), .circle(circ_w),
      .line_count(lc[gi]), .won(won[gi]), .timeout_flag(tflag[gi])
    );
    assign map_a[gi]  = 125'(map_w);
    assign circ_a[gi] = 25'(circ_w);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input int d, input int n);
    cur_number[d]  = 5'(n);
    enter_pulse[d] = 1'b1;
    tick();
    enter_pulse[d] = 1'b0;
  endtask

  task automatic rx(input int d, input logic [2:0] t, input int n);
    rx_en[d]   = 1'b1;
    rx_type[d] = t;
    rx_num[d]  = 5'(n);
    tick();
    rx_en[d]   = 1'b0;
  endtask

  task automatic wait_tx(input int d, input logic [2:0] t, input int n, input string tag);
    int k = 0;
    while (tx_en[d] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_txen"}, 128'(tx_en[d]), 128'(1));
    check({tag, "_type"}, 128'(tx_type[d]), 128'(t));
    if (n >= 0) check({tag, "_num"}, 128'(tx_num[d]), 128'(n));
    $display("tx dut%0d %s type=%0d num=%0d", d, tag, tx_type[d], tx_num[d]);
  endtask

  task automatic ack(input int d, input string tag);
    tick();
    check({tag, "_hold"}, 128'({tx_en[d], transmit[d]}), 128'(2'b01));
    inter_ready[d] = 1'b1;
    tick();
    inter_ready[d] = 1'b0;
    check({tag, "_done"}, 128'(transmit[d]), 128'(0));
  endtask

  task automatic peer(input int d, input int n);
    rx(d, SEL_NUM, n);
    tick();
    tick();
  endtask

  task automatic own(input int d, input int n, input string tag);
    enter(d, n);
    tick();
    wait_tx(d, SEL_NUM, n, tag);
    ack(d, tag);
  endtask

  task automatic start_master(input int d, input int cells, input int mid);
    enter(d, 1);
    wait_tx(d, STATE_TURN, 0, "start");
    ack(d, "start");
    for (int i = 1; i <= cells; i++) begin
      enter(d, i);
      if (i == mid) rx(d, STATE_TURN, 0);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [124:0] exp_map;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      ib_rst[d] = 1'b0; cur_number[d] = '0; enter_pulse[d] = 1'b0; inter_ready[d] = 1'b0;
      rx_en[d] = 1'b0; rx_type[d] = '0; rx_num[d] = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_ctl%0d", d),
            128'({transmit[d], tx_en[d], won[d], tflag[d], lc[d], tx_type[d], tx_num[d]}), 128'(0));
      check($sformatf("rst_board%0d", d), 128'({map_a[d], circ_a[d]}), 128'(0));
    end
    rst = 1'b0;
    tick();

    // Slave: number entry with a duplicate and illegal values, then SEND_READY
    rx(0, STATE_TURN, 0);
    for (int i = 1; i <= 25; i++) begin
      enter(0, i);
      if (i == 7) begin
        enter(0, 7);
        enter(0, 0);
        enter(0, 26);
      end
    end
    exp_map = '0;
    for (int k = 0; k < 25; k++) exp_map[5*k +: 5] = 5'(k + 1);
    check("slave_map", 128'(map_a[0]), 128'(exp_map));
    wait_tx(0, STATE_TURN, 0, "slave_ready");
    repeat (3) tick();
    check("slave_ready_wait", 128'({tx_en[0], transmit[0]}), 128'(2'b01));
    inter_ready[0] = 1'b1;
    tick();
    inter_ready[0] = 1'b0;
    check("slave_ready_done", 128'(transmit[0]), 128'(0));
    check("slave_one_txen", 128'(tx_cnt[0]), 128'(1));
    peer(0, 13);
    check("slave_peer13", 128'(circ_a[0]), 128'(25'h1000));
    own(0, 7, "slave_own7");
    check("slave_circ", 128'(circ_a[0]), 128'(25'h1040));
    rx(0, STATE_WIN, 0);
    tick();
    check("slave_lost", 128'(won[0]), 128'(0));
    rx(0, STATE_TURN, 0);
    check("slave_fin_clear", 128'({map_a[0], circ_a[0]}), 128'(0));

    // Slave again, interboard reset while a SEL_NUM is being sent
    rx(0, STATE_TURN, 0);
    for (int i = 1; i <= 25; i++) enter(0, i);
    wait_tx(0, STATE_TURN, 0, "slave_ready2");
    ack(0, "slave_ready2");
    peer(0, 1);
    enter(0, 2);
    tick();
    wait_tx(0, SEL_NUM, 2, "slave_sel2");
    ib_rst[0] = 1'b1;
    tick();
    ib_rst[0] = 1'b0;
    check("ibrst_tx", 128'({tx_en[0], transmit[0]}), 128'(0));
    check("ibrst_board", 128'({map_a[0], circ_a[0]}), 128'(0));
    rx(0, SEL_NUM, 5);
    tick();
    check("ibrst_idle_drop", 128'(circ_a[0]), 128'(0));

    // Master N=5: peer ready latched mid-entry, guess loop, win on peer guess
    start_master(1, 25, 12);
    enter(1, 1);
    check("master_next_guess", 128'(circ_a[1]), 128'(25'h1));
    tick();
    wait_tx(1, SEL_NUM, 1, "m_own1");
    inter_ready[1] = 1'b1;
    tick();
    check("m_no_exit_on_txen", 128'({tx_en[1], transmit[1]}), 128'(2'b01));
    tick();
    inter_ready[1] = 1'b0;
    check("m_exit_after_txen", 128'(transmit[1]), 128'(0));
    peer(1, 10);
    own(1, 2, "m_own2");
    peer(1, 15);
    own(1, 3, "m_own3");
    peer(1, 20);
    own(1, 4, "m_own4");
    peer(1, 5);
    wait_tx(1, STATE_WIN, -1, "m_win");
    check("m_circ", 128'(circ_a[1]), 128'(25'h8421F));
    ack(1, "m_win");
    check("m_won", 128'({won[1], lc[1]}), 128'({1'b1, 4'd1}));

    // Master N=3, two lines needed
    start_master(2, 9, 3);
    own(2, 1, "n3_own1");
    peer(2, 2);
    enter(2, 3);
    tick();
    wait_tx(2, SEL_NUM, 3, "n3_own3");
    check("n3_lc1", 128'(lc[2]), 128'(1));
    ack(2, "n3_own3");
    peer(2, 4);
    enter(2, 7);
    tick();
    wait_tx(2, STATE_WIN, -1, "n3_win");
    check("n3_lc2", 128'(lc[2]), 128'(2));
    ack(2, "n3_win");
    check("n3_won", 128'(won[2]), 128'(1));

    // Master with an 8-cycle turn timeout
    start_master(3, 25, 20);
    own(3, 1, "to_own1");
    peer(3, 2);
    repeat (7) tick();
    check("to_before", 128'({tflag[3], transmit[3]}), 128'(0));
    tick();
    check("to_pulse", 128'(tflag[3]), 128'(1));
    tick();
    check("to_pulse_end", 128'(tflag[3]), 128'(0));
    wait_tx(3, SEL_NUM, 3, "to_auto");
    check("to_circ", 128'(circ_a[3]), 128'(25'h7));
    ack(3, "to_auto");
    peer(3, 10);
    repeat (7) tick();
    enter(3, 12);
    check("to_user_wins", 128'(tflag[3]), 128'(0));
    tick();
    wait_tx(3, SEL_NUM, 12, "to_user");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
